// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants, FSM encoding and a small helper for the interrupt pending controller.
package irq_pending_ctrl_pkg;

  localparam int NREQ = 8;
  localparam int VW   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] vec_onehot(input logic [VW-1:0] v);
    return {{(NREQ-1){1'b0}}, 1'b1} << v;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc8.sv
// Eight-input priority encoder: the highest set bit wins; any flags a non-empty input.
module prio_enc8 (
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       any
);

  // Ascending scan so the last hit, i.e. the highest index, is what remains.
  always_comb begin
    idx = 3'd0;
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in[i]) begin
        idx = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Latches rising edges on asynchronous request lines and serves them one at a time
// to a consumer through an irq/vec/ack handshake, tracking lines that overflowed.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic            ack,
  input  logic            clr_lost,
  output logic            irq,
  output logic [VW-1:0]   vec,
  output logic [NREQ-1:0] pending,
  output logic [NREQ-1:0] lost,
  output state_t          dbg_state
);

  // Handshake: irq rises with a stable vec; the consumer raises ack, which is
  // taken on the first edge it is seen in ASSERT (irq drops at that edge). A
  // new irq can only follow once ack has been seen low again.

  logic [NREQ-1:0] sync1;
  logic [NREQ-1:0] sync2;
  logic [NREQ-1:0] prev;
  logic [NREQ-1:0] rise;
  logic [NREQ-1:0] clr;
  logic [NREQ-1:0] eligible;
  logic [VW-1:0]   win_idx;
  logic            win_any;
  state_t          state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise     = sync2 & ~prev;
  assign clr      = (state == ASSERT && ack) ? vec_onehot(vec) : '0;
  assign eligible = pending & mask;

  prio_enc8 u_prio (
    .in  (eligible),
    .idx (win_idx),
    .any (win_any)
  );

  // A new edge overrides a same-cycle clear, and only counts as lost when the
  // line stays pending through this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      lost    <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      lost    <= (clr_lost ? '0 : lost) | (rise & pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      irq   <= 1'b0;
      vec   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            vec   <= win_idx;
            irq   <= 1'b1;
            state <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack) begin
            irq   <= 1'b0;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!ack) state <= IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 Parameter: NREQ, 8, number of request lines; fixed at 8 for this revision.
REQ-002 Parameter: VW, 3, vector width (log2 NREQ).
REQ-003 Port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: req  in  8  asynchronous request lines; an event is a 0->1 transition.
REQ-006 Port: mask  in  8  1 = line enabled for irq generation; 0 = line latched but not signalled.
REQ-007 Port: ack  in  1  consumer acknowledge (level, synchronous to clk).
REQ-008 Port: clr_lost  in  1  synchronous clear of all lost flags.
REQ-009 Port: irq  out  1  registered interrupt request to consumer.
REQ-010 Port: vec  out  3  registered index of the request being served; valid while irq=1.
REQ-011 Port: pending  out  8  registered pending-event register (drives the priority encoder input).
REQ-012 Port: lost  out  8  sticky per-line flag: an event arrived while that line was already pending.

Function
REQ-013 Each req bit SHALL pass through a 2-flop synchronizer followed by a registered-previous-value edge detector.
REQ-014 With req[i] first sampled high at edge E0, pending[i] SHALL read 1 after E2; a req pulse shorter than one clock period MAY be missed.
REQ-015 Priority SHALL be highest index wins among bits where pending & mask = 1 (bit 7 highest).
REQ-016 FSM states: IDLE, ASSERT, WAIT_REL; encoded in 2 bits.
REQ-017 IDLE: when (pending & mask) != 0, at the next edge register vec = winner, irq = 1, go to ASSERT; the path from req at E0 to irq = 1 is complete after E3.
REQ-018 ASSERT: vec and irq SHALL hold stable; no preemption by higher-priority arrivals and no withdrawal when mask changes.
REQ-019 ASSERT with ack = 1 sampled: clear pending[vec], irq = 0, go to WAIT_REL, all at the same edge.
REQ-020 WAIT_REL: remain while ack = 1; go to IDLE on the first edge with ack = 0; no new irq is issued from WAIT_REL.
REQ-021 ack in IDLE or WAIT_REL SHALL be ignored (no pending bit change).
REQ-022 Simultaneous clear of pending[i] and a new detected edge on line i: set wins; pending[i] stays 1; lost[i] unchanged.
REQ-023 Detected edge on line i while pending[i] = 1 and not being cleared that cycle: lost[i] set to 1.
REQ-024 clr_lost = 1 clears all lost bits; a lost set event in the same cycle wins for that bit.
REQ-025 Masked lines SHALL still set pending and lost; unmasking a pending line makes it eligible in the next IDLE evaluation.
REQ-026 Minimum back-to-back service: a second pending line raises irq 2 edges after ack is deasserted.

Reset
REQ-027 rst_n = 0 SHALL immediately force: state = IDLE, irq = 0, vec = 0, pending = 0, lost = 0, synchronizer and edge-detect flops = 0.
REQ-028 After rst_n deasserts, a req line already held high SHALL be detected as one event (synchronizer reset to 0).
REQ-029 Reset asserted in ASSERT or WAIT_REL SHALL abandon the transaction with no further irq for it.

Structure
REQ-030 A shared package SHALL hold: NREQ, VW, the FSM state encodings (IDLE = 0, ASSERT = 1, WAIT_REL = 2).
REQ-031 The winner selection SHALL be one combinational sub-module, prio_enc8 (in 8, out index 3 plus any-valid), instantiated once on pending & mask.
REQ-032 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.

Verification
REQ-033 Reset check: rst_n low mid-ASSERT with pending = 8'h84 -> irq, vec, pending, lost all read 0 asynchronously; stays IDLE after release.
REQ-034 Single event: mask = 8'hFF; req[2] 0->1 at E0 -> pending = 8'h04 after E2; irq = 1, vec = 2 after E3; ack high for one cycle -> pending = 0, irq = 0.
REQ-035 Priority and no preemption: pending = 8'h09 gives vec = 3; req[7] arrives during ASSERT -> vec stays 3; after ack and release, next vec = 7, then vec = 0.
REQ-036 Mask: mask = 8'h00 with req[5] edge -> pending = 8'h20, irq stays 0; mask = 8'h20 -> irq = 1, vec = 5.
REQ-037 Lost and simultaneous events: second edge on req[1] while pending -> lost = 8'h02; clr_lost -> 8'h00; edge on line 4 in the same cycle as ack clears pending[4] -> pending[4] stays 1.
REQ-038 Sweep: set req[0..7] one per 25 ns, then clear them in order -> vecs served in strictly descending order, with exactly one irq per detected edge.
